// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared constants for the RV32I decode stage.
//   opcode_e      : major opcodes recognised by the decoder, including loads
//                   (INST_TYPE_L) and stores (INST_TYPE_S)
//   FUNC7_*       : func7 patterns that separate base, alternate (sub/sra)
//                   and multiply/divide encodings (INST_MUL_DIV)
//   INST_NOP      : addi x0,x0,0, the word shown on inst_o for a bubble
// -----------------------------------------------------------------------------
package id_stage_pkg;

   typedef enum logic [6:0] {
      INST_TYPE_LUI   = 7'b0110111,
      INST_TYPE_AUIPC = 7'b0010111,
      INST_TYPE_JAL   = 7'b1101111,
      INST_TYPE_JALR  = 7'b1100111,
      INST_TYPE_B     = 7'b1100011,
      INST_TYPE_L     = 7'b0000011,
      INST_TYPE_S     = 7'b0100011,
      INST_TYPE_I     = 7'b0010011,
      INST_TYPE_R     = 7'b0110011
   } opcode_e;

   localparam logic [6:0]  FUNC7_BASE   = 7'b0000000;
   localparam logic [6:0]  FUNC7_ALT    = 7'b0100000;
   localparam logic [6:0]  INST_MUL_DIV = 7'b0000001;

   localparam logic [2:0]  FUNC3_SLL    = 3'b001;
   localparam logic [2:0]  FUNC3_SR     = 3'b101;
   localparam logic [2:0]  FUNC3_ADD    = 3'b000;

   localparam logic [31:0] INST_NOP     = 32'h00000013;

endpackage

// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Decode-to-execute bus: the registered decode bundle plus its valid/ready
// handshake.
//   master : decode stage (drives everything except dec_ready_i)
//   slave  : execute stage (drives dec_ready_i)
// -----------------------------------------------------------------------------
interface id_stage_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   logic               dec_valid_o;
   logic               dec_ready_i;
   logic [31:0]        inst_o;
   logic [XLEN-1:0]    inst_addr_o;
   logic [XLEN-1:0]    op1_o;
   logic [XLEN-1:0]    op2_o;
   logic [RADDR_W-1:0] rd_addr_o;
   logic               reg_wen_o;
   logic [XLEN-1:0]    base_addr_o;
   logic [XLEN-1:0]    addr_offset_o;
   logic               mem_ren_o;
   logic               mem_wen_o;
   logic               illegal_o;

   modport master (
      output dec_valid_o, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o,
             reg_wen_o, base_addr_o, addr_offset_o, mem_ren_o, mem_wen_o,
             illegal_o,
      input  dec_ready_i
   );

   modport slave (
      input  dec_valid_o, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o,
             reg_wen_o, base_addr_o, addr_offset_o, mem_ren_o, mem_wen_o,
             illegal_o,
      output dec_ready_i
   );
endinterface

// File: rtl/id_stage_decode.sv
// -----------------------------------------------------------------------------
// id_decode
// Purely combinational RV32I decoder: instruction word, PC and the (already
// bypassed) register values in, decoded operand/control bundle out.
// Config macro: ID_RV32M_EN -- when defined, R-type with func7=0000001 is a
// legal M op; otherwise it is flagged illegal.
// Ports:
//   inst, pc, rs1_val, rs2_val     : inputs
//   op1, op2, base_addr,
//   addr_offset, rd_addr           : decoded datapath fields
//   reg_wen, mem_ren, mem_wen      : decoded controls
//   illegal                        : encoding not recognised
//   rs1_used, rs2_used             : which sources the instruction reads
// -----------------------------------------------------------------------------
module id_decode
   import id_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic [31:0]        inst,
   input  logic [XLEN-1:0]    pc,
   input  logic [XLEN-1:0]    rs1_val,
   input  logic [XLEN-1:0]    rs2_val,
   output logic [XLEN-1:0]    op1,
   output logic [XLEN-1:0]    op2,
   output logic [XLEN-1:0]    base_addr,
   output logic [XLEN-1:0]    addr_offset,
   output logic [RADDR_W-1:0] rd_addr,
   output logic               reg_wen,
   output logic               mem_ren,
   output logic               mem_wen,
   output logic               illegal,
   output logic               rs1_used,
   output logic               rs2_used
);

   opcode_e            opcode;
   logic [2:0]         func3;
   logic [6:0]         func7;
   logic [RADDR_W-1:0] rd;
   logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

   // Immediates are sign-extended by casting the signed field up to XLEN
   assign opcode = opcode_e'(inst[6:0]);
   assign func3  = inst[14:12];
   assign func7  = inst[31:25];
   assign rd     = RADDR_W'(inst[11:7]);
   assign imm_i  = XLEN'($signed(inst[31:20]));
   assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
   assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
   assign shamt  = XLEN'(inst[24:20]);

   // Per-opcode field selection; anything flagged illegal is scrubbed back to
   // all-zero at the end so execute never sees half-decoded garbage
   always_comb begin
      op1         = '0;
      op2         = '0;
      base_addr   = '0;
      addr_offset = '0;
      rd_addr     = '0;
      reg_wen     = 1'b0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      illegal     = 1'b0;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
      case (opcode)
         INST_TYPE_I: begin
            rs1_used = 1'b1;
            reg_wen  = 1'b1;
            rd_addr  = rd;
            op1      = rs1_val;
            op2      = imm_i;
            if (func3 == FUNC3_SLL) begin
               op2     = shamt;
               illegal = (func7 != FUNC7_BASE);
            end else if (func3 == FUNC3_SR) begin
               op2     = shamt;
               illegal = !(func7 == FUNC7_BASE || func7 == FUNC7_ALT);
            end
         end
         INST_TYPE_R: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            reg_wen  = 1'b1;
            rd_addr  = rd;
            op1      = rs1_val;
            op2      = rs2_val;
            if (func7 == INST_MUL_DIV) begin
`ifdef ID_RV32M_EN
               illegal = 1'b0;
`else
               illegal = 1'b1;
`endif
            end else begin
               if (func3 == FUNC3_SLL || func3 == FUNC3_SR)
                  op2 = XLEN'(rs2_val[4:0]);
               // only add/sub and srl/sra have an alternate func7
               illegal = !(func7 == FUNC7_BASE ||
                           (func7 == FUNC7_ALT && (func3 == FUNC3_ADD || func3 == FUNC3_SR)));
            end
         end
         INST_TYPE_B: begin
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
            op1         = rs1_val;
            op2         = rs2_val;
            base_addr   = pc;
            addr_offset = imm_b;
            illegal     = (func3 == 3'b010) || (func3 == 3'b011);
         end
         INST_TYPE_JAL: begin
            reg_wen     = 1'b1;
            rd_addr     = rd;
            op1         = pc;
            op2         = XLEN'(4);
            base_addr   = pc;
            addr_offset = imm_j;
         end
         INST_TYPE_JALR: begin
            rs1_used    = 1'b1;
            reg_wen     = 1'b1;
            rd_addr     = rd;
            op1         = pc;
            op2         = XLEN'(4);
            base_addr   = rs1_val;
            addr_offset = imm_i;
            illegal     = (func3 != 3'b000);
         end
         INST_TYPE_LUI: begin
            reg_wen = 1'b1;
            rd_addr = rd;
            op1     = imm_u;
         end
         INST_TYPE_AUIPC: begin
            reg_wen = 1'b1;
            rd_addr = rd;
            op1     = imm_u;
            op2     = pc;
         end
         INST_TYPE_L: begin
            rs1_used    = 1'b1;
            reg_wen     = 1'b1;
            mem_ren     = 1'b1;
            rd_addr     = rd;
            op1         = rs1_val;
            base_addr   = rs1_val;
            addr_offset = imm_i;
            illegal     = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
         end
         INST_TYPE_S: begin
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
            mem_wen     = 1'b1;
            op1         = rs1_val;
            op2         = rs2_val;
            base_addr   = rs1_val;
            addr_offset = imm_s;
            illegal     = (func3 > 3'b010);
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         op1         = '0;
         op2         = '0;
         base_addr   = '0;
         addr_offset = '0;
         rd_addr     = '0;
         reg_wen     = 1'b0;
         mem_ren     = 1'b0;
         mem_wen     = 1'b0;
         rs1_used    = 1'b0;
         rs2_used    = 1'b0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Registered RV32I decode stage (decode logic + id_ex register).
// Config macro: ID_RV32M_EN (passed down to id_decode) enables M-extension
// R-type encodings; undefined, they are flagged illegal.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   inst_valid_i/inst_ready_o,
//   inst_i, inst_addr_i            : upstream instruction handshake
//   rs1/rs2_addr_o, rs1/rs2_data_i : register file read port
//   wb_wen_i, wb_rd_i, wb_data_i   : write-back, bypassed into operands
//   flush_i                        : kill stage contents (taken branch/jump)
//   dec                            : registered decode bus to execute
// -----------------------------------------------------------------------------
module id_stage
   import id_stage_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          RADDR_W  = 5,
   parameter logic [31:0] NOP_INST = INST_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inst_valid_i,
   output logic               inst_ready_o,
   input  logic [31:0]        inst_i,
   input  logic [XLEN-1:0]    inst_addr_i,
   output logic [RADDR_W-1:0] rs1_addr_o,
   output logic [RADDR_W-1:0] rs2_addr_o,
   input  logic [XLEN-1:0]    rs1_data_i,
   input  logic [XLEN-1:0]    rs2_data_i,
   input  logic               wb_wen_i,
   input  logic [RADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]    wb_data_i,
   input  logic               flush_i,
   id_stage_if.master         dec
);

   logic [XLEN-1:0]    rs1_val, rs2_val;
   logic [XLEN-1:0]    d_op1, d_op2, d_base, d_offset;
   logic [RADDR_W-1:0] d_rd;
   logic               d_reg_wen, d_mem_ren, d_mem_wen, d_illegal;
   logic               d_rs1_used, d_rs2_used;
   logic               load_en, hz;

   assign rs1_addr_o = RADDR_W'(inst_i[19:15]);
   assign rs2_addr_o = RADDR_W'(inst_i[24:20]);

   // x0 reads zero; otherwise a same-cycle write-back to the source wins over
   // the stale register-file value
   assign rs1_val = (rs1_addr_o == '0) ? '0 :
                    (wb_wen_i && wb_rd_i == rs1_addr_o) ? wb_data_i : rs1_data_i;
   assign rs2_val = (rs2_addr_o == '0) ? '0 :
                    (wb_wen_i && wb_rd_i == rs2_addr_o) ? wb_data_i : rs2_data_i;

   id_decode #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W)
   ) u_decode (
      .inst        (inst_i),
      .pc          (inst_addr_i),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .op1         (d_op1),
      .op2         (d_op2),
      .base_addr   (d_base),
      .addr_offset (d_offset),
      .rd_addr     (d_rd),
      .reg_wen     (d_reg_wen),
      .mem_ren     (d_mem_ren),
      .mem_wen     (d_mem_wen),
      .illegal     (d_illegal),
      .rs1_used    (d_rs1_used),
      .rs2_used    (d_rs2_used)
   );

   // A load sitting in the register cannot forward its data yet, so an
   // instruction that reads its destination must wait one cycle
   assign load_en = !dec.dec_valid_o || dec.dec_ready_i;
   assign hz      = dec.dec_valid_o && dec.mem_ren_o && (dec.rd_addr_o != '0) &&
                    ((d_rs1_used && dec.rd_addr_o == rs1_addr_o) ||
                     (d_rs2_used && dec.rd_addr_o == rs2_addr_o));
   assign inst_ready_o = load_en && !hz;

   // id_ex register. Reset, flush (even under backpressure) and a load-use
   // stall all leave the same bubble, so they share one branch with reset
   // listed first; otherwise the register only moves when execute can take it
   always_ff @(posedge clk) begin
      if (!rst || flush_i || (load_en && hz)) begin
         dec.dec_valid_o   <= 1'b0;
         dec.inst_o        <= NOP_INST;
         dec.inst_addr_o   <= '0;
         dec.op1_o         <= '0;
         dec.op2_o         <= '0;
         dec.rd_addr_o     <= '0;
         dec.reg_wen_o     <= 1'b0;
         dec.base_addr_o   <= '0;
         dec.addr_offset_o <= '0;
         dec.mem_ren_o     <= 1'b0;
         dec.mem_wen_o     <= 1'b0;
         dec.illegal_o     <= 1'b0;
      end else if (load_en) begin
         dec.dec_valid_o   <= inst_valid_i;
         dec.inst_o        <= inst_i;
         dec.inst_addr_o   <= inst_addr_i;
         dec.op1_o         <= d_op1;
         dec.op2_o         <= d_op2;
         dec.rd_addr_o     <= d_rd;
         dec.reg_wen_o     <= d_reg_wen;
         dec.base_addr_o   <= d_base;
         dec.addr_offset_o <= d_offset;
         dec.mem_ren_o     <= d_mem_ren;
         dec.mem_wen_o     <= d_mem_wen;
         dec.illegal_o     <= d_illegal;
      end
   end

endmodule
